// File: rtl/wormhole_pkg.sv
// Shared types and constants for the wormhole controller and its LFSR.
package wormhole_pkg;

    typedef enum logic [0:0] {
        ACTIVE   = 1'b0,
        COOLDOWN = 1'b1
    } wh_state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          POS_W     = 11;

    // One step of a right-shifting Galois LFSR: the bit shifted out
    // selects whether the tap pattern is folded back in.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/wormhole_controller_lfsr16.sv
// Free-running 16-bit Galois LFSR; shared by the randomised spawners.
module lfsr16
    import wormhole_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetN,
    output logic [15:0] value_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next value is always one LFSR step ahead; there is no hold input.
    always_comb begin
        lfsr_d = lfsr_step(lfsr_q);
    end

    // State register, seeded on reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/wormhole_controller.sv
// Wormhole position, visibility and teleport control. Overlap between the
// ship and wormhole pixels is latched over a frame and acted on at the next
// startOfFrame, so every position/visibility change lands on a frame edge.
module wormhole_controller
    import wormhole_pkg::*;
#(
    parameter int          OBJECT_WIDTH_X  = 32,
    parameter int          OBJECT_HEIGHT_Y = 32,
    parameter int          INIT_X          = 100,
    parameter int          INIT_Y          = 100,
    parameter int          EXIT_X          = 500,
    parameter int          EXIT_Y          = 300,
    parameter int          X_MIN           = 32,
    parameter int          Y_MIN           = 32,
    parameter int          COOLDOWN_FRAMES = 60,
    parameter int          RELOCATE_FRAMES = 600,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    enable,
    input  logic                    shipDrawingRequest,
    input  logic                    wormholeDrawingRequest,
    output logic signed [POS_W-1:0] topLeftX,
    output logic signed [POS_W-1:0] topLeftY,
    output logic                    visible,
    output logic                    teleportReq,
    output logic signed [POS_W-1:0] teleportX,
    output logic signed [POS_W-1:0] teleportY
);

    // Configuration sanity: these blocks only exist in the elaborated
    // hierarchy for a broken parameter set, which makes it easy to spot.
    if (OBJECT_WIDTH_X < 1 || OBJECT_HEIGHT_Y < 1) begin : g_bad_object_size
    end
    if (COOLDOWN_FRAMES < 1 || COOLDOWN_FRAMES > 255) begin : g_bad_cooldown
    end
    if (RELOCATE_FRAMES < 1 || RELOCATE_FRAMES > 1023) begin : g_bad_relocate
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    end

    localparam logic [7:0]       CD_LOAD   = 8'(COOLDOWN_FRAMES);
    localparam logic [9:0]       RELOC_END = 10'(RELOCATE_FRAMES - 1);
    localparam logic [POS_W-1:0] X_BASE    = POS_W'(X_MIN);
    localparam logic [POS_W-1:0] Y_BASE    = POS_W'(Y_MIN);

    wh_state_t        state_q, state_d;
    logic [POS_W-1:0] x_q, x_d;
    logic [POS_W-1:0] y_q, y_d;
    logic             visible_q, visible_d;
    logic             teleport_q, teleport_d;
    logic             hit_q, hit_d;
    logic [7:0]       cooldown_q, cooldown_d;
    logic [9:0]       reloc_q, reloc_d;

    logic [15:0]      lfsr;
    logic [POS_W-1:0] new_x;
    logic [POS_W-1:0] new_y;
    logic             overlap;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .resetN  (resetN),
        .value_o (lfsr)
    );

    // Candidate relocation target from the current LFSR value; no clamping,
    // the window parameters are chosen so the object stays on screen.
    assign new_x   = X_BASE + {2'b00, lfsr[8:0]};
    assign new_y   = Y_BASE + {3'b000, lfsr[15:8]};
    assign overlap = shipDrawingRequest && wormholeDrawingRequest;

    // Next-state and output decode; everything acts only when enabled.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        visible_d  = visible_q;
        teleport_d = 1'b0;
        cooldown_d = cooldown_q;
        reloc_d    = reloc_q;
        // The latch is consumed at every frame start, even while frozen.
        hit_d      = startOfFrame ? 1'b0 : hit_q;

        if (enable) begin
            case (state_q)
                ACTIVE: begin
                    if (startOfFrame && hit_q) begin
                        teleport_d = 1'b1;
                        state_d    = COOLDOWN;
                        cooldown_d = CD_LOAD;
                        visible_d  = 1'b0;
                        reloc_d    = 10'd0;
                    end else begin
                        if (startOfFrame) begin
                            if (reloc_q == RELOC_END) begin
                                x_d     = new_x;
                                y_d     = new_y;
                                reloc_d = 10'd0;
                            end else begin
                                reloc_d = reloc_q + 10'd1;
                            end
                        end
                        // An overlap on the SOF pixel belongs to the new frame.
                        if (overlap) begin
                            hit_d = 1'b1;
                        end
                    end
                end
                COOLDOWN: begin
                    if (startOfFrame) begin
                        if (cooldown_q == 8'd1) begin
                            cooldown_d = 8'd0;
                            x_d        = new_x;
                            y_d        = new_y;
                            visible_d  = 1'b1;
                            state_d    = ACTIVE;
                        end else begin
                            cooldown_d = cooldown_q - 8'd1;
                        end
                    end
                end
                default: state_d = ACTIVE;
            endcase
        end
    end

    // State register; reset drops any pending teleport immediately.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ACTIVE;
            x_q        <= POS_W'(INIT_X);
            y_q        <= POS_W'(INIT_Y);
            visible_q  <= 1'b1;
            teleport_q <= 1'b0;
            hit_q      <= 1'b0;
            cooldown_q <= 8'd0;
            reloc_q    <= 10'd0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            visible_q  <= visible_d;
            teleport_q <= teleport_d;
            hit_q      <= hit_d;
            cooldown_q <= cooldown_d;
            reloc_q    <= reloc_d;
        end
    end

    assign topLeftX    = x_q;
    assign topLeftY    = y_q;
    assign visible     = visible_q;
    assign teleportReq = teleport_q;
    assign teleportX   = POS_W'(EXIT_X);
    assign teleportY   = POS_W'(EXIT_Y);

endmodule

// File: doc/wormhole_controller.md
# wormhole_controller

Owns one wormhole's screen position and teleport behaviour; it is the upstream end of the wormhole object drawer. It drives the drawer's `topLeftX`/`topLeftY` and consumes the drawer's `drawingRequest` together with the spaceship's `drawingRequest`. It detects ship/wormhole pixel overlap and issues a one-cycle teleport request at frame start. It then hides the wormhole for a cooldown and relocates it pseudo-randomly. Positions change only at frame boundaries, so the picture never tears.

## Interface
- OBJECT_WIDTH_X, 32, wormhole width in pixels; documents the relocation window.
- OBJECT_HEIGHT_Y, 32, wormhole height in pixels; documents the relocation window.
- INIT_X / INIT_Y, 100 / 100, position after reset.
- EXIT_X / EXIT_Y, 500 / 300, ship destination on teleport.
- X_MIN / Y_MIN, 32 / 32, relocation window origin.
- COOLDOWN_FRAMES, 60, frames the wormhole stays hidden after a hit; valid range 1..255.
- RELOCATE_FRAMES, 600, frames without a hit before a forced relocation; valid range 1..1023.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
- clk  in  1  system clock.
- resetN  in  1  reset, asynchronous, active-low.
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame.
- enable  in  1  game running; low freezes the block.
- shipDrawingRequest  in  1  spaceship drawer is drawing the current pixel.
- wormholeDrawingRequest  in  1  wormhole drawer is drawing the current pixel.
- topLeftX  out  11 signed  wormhole top-left X, to the drawer.
- topLeftY  out  11 signed  wormhole top-left Y, to the drawer.
- visible  out  1  wormhole is shown; the drawing mux gates the wormhole's request with this.
- teleportReq  out  1  one-cycle pulse: ship must jump to teleportX/Y.
- teleportX  out  11 signed  constant EXIT_X.
- teleportY  out  11 signed  constant EXIT_Y.

## Operation
- States: ACTIVE and COOLDOWN.
- Reset values:
  - state ACTIVE
  - topLeftX=INIT_X, topLeftY=INIT_Y
  - visible=1, teleportReq=0
  - hitLatch=0
  - cooldownCnt=0, relocCnt=0
  - lfsr=LFSR_SEED
- Hit detection: in ACTIVE with enable=1, any cycle where shipDrawingRequest && wormholeDrawingRequest sets hitLatch.
- hitLatch clears on startOfFrame, after it has been evaluated.
- Collision in the startOfFrame cycle itself: it is counted in the new frame, i.e. hitLatch ends that cycle set.
- ACTIVE, startOfFrame, hitLatch=1:
  - teleportReq=1 for the next cycle only
  - state becomes COOLDOWN
  - cooldownCnt=COOLDOWN_FRAMES
  - visible=0
  - relocCnt=0
- ACTIVE, startOfFrame, hitLatch=0:
  - relocCnt increments.
  - If it would reach RELOCATE_FRAMES: relocate and set relocCnt=0.
- COOLDOWN, startOfFrame: cooldownCnt decrements. On reaching 0: relocate, visible=1, state ACTIVE.
- COOLDOWN ignores collisions; hitLatch stays 0.
- Relocate, using the current lfsr value:
  - topLeftX = X_MIN + lfsr[8:0], range 32..543 at defaults.
  - topLeftY = Y_MIN + lfsr[15:8], range 32..287 at defaults.
  - Both are zero-extended to 11 bits and added unsigned.
  - No clamping; the caller picks the window so that position + size fits the screen.
- LFSR: 16-bit Galois, taps 16'hB400, shifts right every clk cycle. It free-runs regardless of enable, so position depends on play timing.
- enable=0:
  - no hitLatch set
  - no teleportReq
  - counters, state and position frozen
  - startOfFrame ignored, except that hitLatch still clears
- Reset mid-cooldown or mid-frame: all values return immediately to their reset values. Any pending teleport is dropped.

## Timing
- All outputs are registered.
- topLeftX/Y and visible change only in the cycle after startOfFrame. They are stable for the whole visible frame.
- teleportReq is asserted exactly in cycle SOF+1, for 1 cycle, at most once per frame.
- Latency from the first overlapping pixel to teleportReq: the rest of that frame, plus 1 cycle after the next startOfFrame.
- Wormhole is hidden for exactly COOLDOWN_FRAMES full frames. It reappears at the new position in the frame that starts at the SOF where cooldownCnt hits 0.
- Forced relocation fires on the RELOCATE_FRAMES-th consecutive hit-free SOF.
- Counter widths: cooldownCnt 8 bits, relocCnt 10 bits.

## Structure
- Package `wormhole_pkg`:
  - `typedef enum logic [0:0] {ACTIVE, COOLDOWN} wh_state_t`
  - `LFSR_TAPS = 16'hB400`
  - `POS_W = 11`
- Sub-module `lfsr16` (clk, resetN, seed param, 16-bit out, always-advance). It is reused by other randomised spawners.
- The teleportX/Y outputs are continuous assigns from the parameters.

## Test plan
Bench parameters: COOLDOWN_FRAMES=3, RELOCATE_FRAMES=5, short frames of 100 cycles.
- Reset: after resetN rises, topLeftX=100, topLeftY=100, visible=1, teleportReq=0.
- Overlap at cycle 40 of frame 0 -> at SOF+1 of frame 1: teleportReq=1 for exactly 1 cycle and visible=0; over frames 1-3: no further pulses; at SOF of frame 4: visible=1 with the position equal to X_MIN+lfsr[8:0] and Y_MIN+lfsr[15:8] sampled at that SOF.
- No overlap for 5 frames -> at the 5th SOF the position changes to the LFSR-derived value; teleportReq stays 0.
- Overlap at the exact startOfFrame cycle -> teleportReq fires at the following SOF+1, not the current one; overlap during COOLDOWN -> no pulse.
- enable=0 during an overlap frame -> no teleportReq and counters frozen; re-enable -> relocation resumes counting from the frozen value.
- resetN pulsed low mid-COOLDOWN (cooldownCnt=2) -> outputs return to reset values asynchronously; state ACTIVE and visible=1 after release.
